rs_alu: RTL and testbench
=========================

RS_ALU -- requirements
Module: rs_alu

Interface
REQ-001 The block SHALL have parameter RS_SIZE, default 8, meaning the number of reservation entries (power of two, 2..16).
REQ-002 The block SHALL have parameter AGE_W, default 3, meaning the per-entry age counter width (used only under RS_OLDEST_FIRST_EN).
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 clear  in  1  pipeline flush on jump or mispredict.
REQ-006 dispEn  in  1  dispatch request.
REQ-007 dispOp  in  OP_W  opcode; dispAddr  in  32  instruction address.
REQ-008 dispValO/dispValT  in  32 each  operand values; dispTagO/dispTagT  in  TAG_W each  producer tags, tagFree meaning the value is valid.
REQ-009 dispWrtTag  in  TAG_W  destination ROB tag; dispName  in  NAME_W  destination register name.
REQ-010 cdbEn, cdbTag, cdbData  in  1/TAG_W/32  ALU result broadcast.
REQ-011 lsbEn, lsbTag, lsbData  in  1/TAG_W/32  load result broadcast.
REQ-012 rsFull  out  1  registered back-pressure to the dispatcher.
REQ-013 ALUworkEn  out  1  issue valid; operandO, operandT  out  32 each; wrtTag  out  TAG_W; wrtName  out  NAME_W; opCode  out  OP_W; instAddr  out  32.

Function
REQ-014 Each entry SHALL hold: valid, op, addr, wrtTag, name, and for each operand a 32-bit value plus a TAG_W tag.
REQ-015 An entry's operand SHALL be ready when its tag equals tagFree; the entry is ready when valid and both operands are ready.
REQ-016 On dispEn with a free entry, the lowest-index free entry (pre-edge state) SHALL be written at the edge.
REQ-017 dispEn while all entries are valid SHALL be ignored with no state change.
REQ-018 Wakeup: for every valid waiting operand, cdbEn && cdbTag==tag (else lsbEn && lsbTag==tag) SHALL load the matching data and set the tag to tagFree at the edge.
REQ-019 Dispatch bypass: a dispatched operand whose tag matches an active broadcast in the same cycle SHALL be stored ready with the broadcast data.
REQ-020 Each cycle, the lowest-index ready entry SHALL be selected and freed at the edge; the ALU outputs SHALL be registered from it and ALUworkEn=1 for exactly one cycle.
REQ-021 With no ready entry, ALUworkEn SHALL be 0 and the data outputs SHALL be dataFree/tagFree/nameFree/addrFree, with opCode all-zero.
REQ-022 Latency: a fully-ready dispatch at edge N SHALL produce ALUworkEn high after edge N+1; an entry woken at edge N SHALL issue after edge N+1.
REQ-023 Dispatch and issue in the same cycle SHALL both occur; a just-freed entry is not reused in that cycle.
REQ-024 rsFull SHALL be registered, 1 when post-edge valid count >= RS_SIZE-1.
REQ-025 clear SHALL invalidate all entries at the edge, force ALUworkEn=0 next cycle and rsFull=0, and drop any same-cycle dispatch; clear has priority over dispatch, wakeup and issue.

Reset
REQ-026 rst SHALL clear all valid bits and drive ALUworkEn=0, rsFull=0, operandO/operandT=dataFree, wrtTag=tagFree, wrtName=nameFree, opCode=0, instAddr=addrFree; rst mid-operation discards all entries.

Configuration
REQ-027 With RS_OLDEST_FIRST_EN defined, each valid entry SHALL have an AGE_W counter, zeroed at dispatch and incremented each cycle (saturating); selection SHALL pick the ready entry with the largest age, ties broken by lowest index.
REQ-028 Without RS_OLDEST_FIRST_EN, no age counters SHALL exist and selection is lowest-index ready.

Structure
REQ-029 DATA_W=32, TAG_W, NAME_W, OP_W, tagFree, nameFree, dataFree, addrFree and the opcode encodings SHALL live in the shared defines package.
REQ-030 Ready selection SHALL be a sub-module rs_select (ready vector, optional ages in; one-hot grant plus any-valid out).

Verification
REQ-031 Ready ADD dispatch, O=5, T=7, wrtTag=3: ALUworkEn=1 two cycles later with operandO=5, operandT=7, wrtTag=3, opCode=ADD.
REQ-032 Dispatch with tagO=2; after 3 cycles cdbEn, tag 2, data 0x1234: issue one cycle after the broadcast with operandO=0x1234.
REQ-033 Dispatch with tagT=4 while lsbEn, tag 4, data 9 in the same cycle: issue on schedule with operandT=9.
REQ-034 Fill 7 waiting entries: rsFull=1; an 8th dispatch is accepted; a 9th is ignored; one wakeup then drops rsFull one cycle after issue.
REQ-035 clear with 4 valid entries plus a same-cycle dispatch: no ALUworkEn afterwards, rsFull=0, later broadcasts cause no issue.
REQ-036 RS_OLDEST_FIRST_EN: entry 5 dispatched before entry 0, both woken by the same broadcast: entry 5 issues first; without the macro, entry 0 issues first.

Source files
------------

// File: rtl/rs_alu_pkg.sv
// rtl/rs_alu_pkg.sv - shared widths, free markers, opcodes, entry types and the operand snoop helper
package rs_alu_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
    localparam int NAME_W = 5;
    localparam int OP_W   = 4;

    // ROB tags live in 0..15; the top tag value marks an operand that already holds its value
    localparam logic [TAG_W-1:0]  tagFree  = 5'h10;
    localparam logic [NAME_W-1:0] nameFree = '0;
    localparam logic [DATA_W-1:0] dataFree = '0;
    localparam logic [31:0]       addrFree = '0;

    localparam logic [OP_W-1:0] OP_NONE = 4'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
    localparam logic [OP_W-1:0] OP_AND  = 4'd3;
    localparam logic [OP_W-1:0] OP_OR   = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd7;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd8;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } operand_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [31:0]       addr;
        logic [TAG_W-1:0]  wrt_tag;
        logic [NAME_W-1:0] name;
        operand_t          opd_o;
        operand_t          opd_t;
    } rs_entry_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [31:0]       addr;
        logic [TAG_W-1:0]  wrt_tag;
        logic [NAME_W-1:0] name;
        logic [DATA_W-1:0] val_o;
        logic [DATA_W-1:0] val_t;
    } issue_t;

    localparam issue_t ISSUE_IDLE = '{op: OP_NONE, addr: addrFree, wrt_tag: tagFree,
                                      name: nameFree, val_o: dataFree, val_t: dataFree};

    // Capture a broadcast result for a waiting operand; the ALU bus wins over the load bus
    function automatic operand_t snoop(
        input operand_t          opd,
        input logic              cdb_en,
        input logic [TAG_W-1:0]  cdb_tag,
        input logic [DATA_W-1:0] cdb_data,
        input logic              lsb_en,
        input logic [TAG_W-1:0]  lsb_tag,
        input logic [DATA_W-1:0] lsb_data
    );
        operand_t res;
        res = opd;
        if (opd.tag != tagFree) begin
            if (cdb_en && cdb_tag == opd.tag) begin
                res.tag = tagFree;
                res.val = cdb_data;
            end else if (lsb_en && lsb_tag == opd.tag) begin
                res.tag = tagFree;
                res.val = lsb_data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_alu_if.sv
// rtl/rs_alu_if.sv - dispatch, broadcast and issue signals of the ALU reservation station
interface rs_alu_if;
    import rs_alu_pkg::*;

    logic              clear;
    logic              dispEn;
    logic [OP_W-1:0]   dispOp;
    logic [31:0]       dispAddr;
    logic [DATA_W-1:0] dispValO;
    logic [DATA_W-1:0] dispValT;
    logic [TAG_W-1:0]  dispTagO;
    logic [TAG_W-1:0]  dispTagT;
    logic [TAG_W-1:0]  dispWrtTag;
    logic [NAME_W-1:0] dispName;
    logic              cdbEn;
    logic [TAG_W-1:0]  cdbTag;
    logic [DATA_W-1:0] cdbData;
    logic              lsbEn;
    logic [TAG_W-1:0]  lsbTag;
    logic [DATA_W-1:0] lsbData;
    logic              rsFull;
    logic              ALUworkEn;
    logic [DATA_W-1:0] operandO;
    logic [DATA_W-1:0] operandT;
    logic [TAG_W-1:0]  wrtTag;
    logic [NAME_W-1:0] wrtName;
    logic [OP_W-1:0]   opCode;
    logic [31:0]       instAddr;

    modport master (
        output clear, dispEn, dispOp, dispAddr, dispValO, dispValT, dispTagO, dispTagT,
               dispWrtTag, dispName, cdbEn, cdbTag, cdbData, lsbEn, lsbTag, lsbData,
        input  rsFull, ALUworkEn, operandO, operandT, wrtTag, wrtName, opCode, instAddr
    );

    modport slave (
        input  clear, dispEn, dispOp, dispAddr, dispValO, dispValT, dispTagO, dispTagT,
               dispWrtTag, dispName, cdbEn, cdbTag, cdbData, lsbEn, lsbTag, lsbData,
        output rsFull, ALUworkEn, operandO, operandT, wrtTag, wrtName, opCode, instAddr
    );
endinterface

// File: rtl/rs_alu_select.sv
// rtl/rs_alu_select.sv - rs_select: one-hot grant of a ready entry (oldest-first under RS_OLDEST_FIRST_EN)
module rs_select #(
    parameter int N     = 8,
    parameter int AGE_W = 3
) (
    input  logic [N-1:0]       ready_i,
`ifdef RS_OLDEST_FIRST_EN
    input  logic [N*AGE_W-1:0] ages_i,
`endif
    output logic [N-1:0]       grant_o,
    output logic               any_o
);

`ifdef RS_OLDEST_FIRST_EN
    logic [AGE_W-1:0] best_age;
    logic             found;

    // Largest age wins; strict compare keeps the lowest index on ties
    always_comb begin
        grant_o  = '0;
        best_age = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ready_i[i] && (!found || ages_i[i*AGE_W +: AGE_W] > best_age)) begin
                found    = 1'b1;
                best_age = ages_i[i*AGE_W +: AGE_W];
                grant_o  = '0;
                grant_o[i] = 1'b1;
            end
        end
    end
`else
    // Isolate the lowest set bit of the ready vector
    always_comb begin
        grant_o = ready_i & (~ready_i + 1'b1);
    end
`endif

    assign any_o = |ready_i;

endmodule

// File: rtl/rs_alu.sv
// rtl/rs_alu.sv - ALU reservation station with wakeup, bypass and flush; RS_OLDEST_FIRST_EN selects oldest-first issue
module rs_alu
    import rs_alu_pkg::*;
#(
    parameter int RS_SIZE = 8,
    parameter int AGE_W   = 3
) (
    input  logic    clk,
    input  logic    rst,
    rs_alu_if.slave bus
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    if (RS_SIZE < 2 || RS_SIZE > 16 || (RS_SIZE & (RS_SIZE - 1)) != 0 || AGE_W < 1) begin : g_bad_cfg
        $error("rs_alu: RS_SIZE must be a power of two in 2..16 and AGE_W at least 1");
    end

    rs_entry_t          ent_q [RS_SIZE];
    rs_entry_t          ent_d [RS_SIZE];
    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [RS_SIZE-1:0] ready, grant;
    logic               any_ready;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               disp_take;
    issue_t             issue_ent;
    issue_t             out_q, out_d;
    logic               work_q, work_d;
    logic               full_q, full_d;
    logic [CNT_W-1:0]   cnt_d;

    // An entry may issue once both operand tags are resolved
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid_q[i] && (ent_q[i].opd_o.tag == tagFree) && (ent_q[i].opd_t.tag == tagFree);
        end
    end

    // Lowest free slot of the pre-edge state, so a slot freed by issue this cycle is not reused
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_take = bus.dispEn && free_found && !bus.clear;

`ifdef RS_OLDEST_FIRST_EN
    logic [AGE_W-1:0]         age_q [RS_SIZE];
    logic [AGE_W-1:0]         age_d [RS_SIZE];
    logic [RS_SIZE*AGE_W-1:0] ages_flat;

    // Ages saturate while an entry is held and restart at dispatch
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!valid_q[i]) begin
                age_d[i] = '0;
            end else if (&age_q[i]) begin
                age_d[i] = age_q[i];
            end else begin
                age_d[i] = age_q[i] + 1'b1;
            end
            ages_flat[i*AGE_W +: AGE_W] = age_q[i];
        end
        if (disp_take) begin
            age_d[free_idx] = '0;
        end
    end

    // Age counters
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            age_q <= age_d;
        end
    end
`endif

    rs_select #(
        .N     (RS_SIZE),
        .AGE_W (AGE_W)
    ) u_select (
        .ready_i (ready),
`ifdef RS_OLDEST_FIRST_EN
        .ages_i  (ages_flat),
`endif
        .grant_o (grant),
        .any_o   (any_ready)
    );

    // Gather the granted entry into the issue record
    always_comb begin
        issue_ent = ISSUE_IDLE;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (grant[i]) begin
                issue_ent.op      = ent_q[i].op;
                issue_ent.addr    = ent_q[i].addr;
                issue_ent.wrt_tag = ent_q[i].wrt_tag;
                issue_ent.name    = ent_q[i].name;
                issue_ent.val_o   = ent_q[i].opd_o.val;
                issue_ent.val_t   = ent_q[i].opd_t.val;
            end
        end
    end

    // Entry next state: wakeup of waiting operands, free on issue, write on dispatch, flush on clear
    always_comb begin
        valid_d = valid_q & ~grant;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (valid_q[i]) begin
                ent_d[i].opd_o = snoop(ent_q[i].opd_o, bus.cdbEn, bus.cdbTag, bus.cdbData,
                                       bus.lsbEn, bus.lsbTag, bus.lsbData);
                ent_d[i].opd_t = snoop(ent_q[i].opd_t, bus.cdbEn, bus.cdbTag, bus.cdbData,
                                       bus.lsbEn, bus.lsbTag, bus.lsbData);
            end
        end
        if (disp_take) begin
            valid_d[free_idx]         = 1'b1;
            ent_d[free_idx].op        = bus.dispOp;
            ent_d[free_idx].addr      = bus.dispAddr;
            ent_d[free_idx].wrt_tag   = bus.dispWrtTag;
            ent_d[free_idx].name      = bus.dispName;
            ent_d[free_idx].opd_o     = snoop('{tag: bus.dispTagO, val: bus.dispValO}, bus.cdbEn,
                                              bus.cdbTag, bus.cdbData, bus.lsbEn, bus.lsbTag, bus.lsbData);
            ent_d[free_idx].opd_t     = snoop('{tag: bus.dispTagT, val: bus.dispValT}, bus.cdbEn,
                                              bus.cdbTag, bus.cdbData, bus.lsbEn, bus.lsbTag, bus.lsbData);
        end
        if (bus.clear) begin
            valid_d = '0;
        end
    end

    // Back-pressure leaves one slot of slack for a dispatch already in flight
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            cnt_d = cnt_d + CNT_W'(valid_d[i]);
        end
        full_d = (cnt_d >= CNT_W'(RS_SIZE - 1));
    end

    // Issue record: granted entry, or the idle markers when nothing issues
    always_comb begin
        work_d = any_ready && !bus.clear;
        out_d  = work_d ? issue_ent : ISSUE_IDLE;
    end

    // Entry payload; only entries with a valid bit are ever observed
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    // Valid bits, issue outputs and full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            work_q  <= 1'b0;
            out_q   <= ISSUE_IDLE;
            full_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            work_q  <= work_d;
            out_q   <= out_d;
            full_q  <= full_d;
        end
    end

    assign bus.rsFull    = full_q;
    assign bus.ALUworkEn = work_q;
    assign bus.operandO  = out_q.val_o;
    assign bus.operandT  = out_q.val_t;
    assign bus.wrtTag    = out_q.wrt_tag;
    assign bus.wrtName   = out_q.name;
    assign bus.opCode    = out_q.op;
    assign bus.instAddr  = out_q.addr;

endmodule

// File: tb/tb_rs_alu.sv
// tb/tb_rs_alu.sv - self-checking bench for rs_alu: directed scenarios plus random traffic against a reference model
module tb_rs_alu;
    import rs_alu_pkg::*;

    localparam int N = 8;
    localparam int AGE_W = 3;
    localparam int AGE_MAX = 7;

    logic clk;
    logic rst;
    rs_alu_if bus();

    rs_alu #(.RS_SIZE(N), .AGE_W(AGE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Reference model: a table of held instructions
    bit                m_valid [N];
    logic [OP_W-1:0]   m_op    [N];
    logic [31:0]       m_addr  [N];
    logic [TAG_W-1:0]  m_wtag  [N];
    logic [NAME_W-1:0] m_name  [N];
    logic [TAG_W-1:0]  m_tag   [N][2];
    logic [31:0]       m_val   [N][2];
    int                m_age   [N];

    logic              e_work, e_full;
    logic [OP_W-1:0]   e_op;
    logic [31:0]       e_addr, e_opo, e_opt;
    logic [TAG_W-1:0]  e_wtag;
    logic [NAME_W-1:0] e_name;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [TAG_W+31:0] resolve(input logic [TAG_W-1:0] tag, input logic [31:0] val);
        if (tag != tagFree && bus.cdbEn && bus.cdbTag == tag) return {tagFree, bus.cdbData};
        if (tag != tagFree && bus.lsbEn && bus.lsbTag == tag) return {tagFree, bus.lsbData};
        return {tag, val};
    endfunction

    task automatic exp_idle();
        e_work = 0; e_op = OP_NONE; e_addr = addrFree; e_opo = dataFree; e_opt = dataFree;
        e_wtag = tagFree; e_name = nameFree;
    endtask

    // Advance the model across one clock edge using the inputs presented during that cycle
    task automatic model_step();
        int sel, fr, cnt;
        if (rst || bus.clear) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            exp_idle();
            e_full = 0;
            return;
        end
        sel = -1;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_tag[i][0] == tagFree && m_tag[i][1] == tagFree) begin
`ifdef RS_OLDEST_FIRST_EN
                if (sel < 0 || m_age[i] > m_age[sel]) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
        end
        fr = -1;
        for (int i = 0; i < N; i++) if (!m_valid[i] && fr < 0) fr = i;
        if (sel >= 0) begin
            e_work = 1; e_op = m_op[sel]; e_addr = m_addr[sel]; e_opo = m_val[sel][0];
            e_opt = m_val[sel][1]; e_wtag = m_wtag[sel]; e_name = m_name[sel];
            m_valid[sel] = 0;
        end else begin
            exp_idle();
        end
        for (int i = 0; i < N; i++) begin
            if (m_valid[i]) begin
                for (int k = 0; k < 2; k++) {m_tag[i][k], m_val[i][k]} = resolve(m_tag[i][k], m_val[i][k]);
            end
            if (m_age[i] < AGE_MAX) m_age[i]++;
        end
        if (bus.dispEn && fr >= 0) begin
            m_valid[fr] = 1; m_op[fr] = bus.dispOp; m_addr[fr] = bus.dispAddr;
            m_wtag[fr] = bus.dispWrtTag; m_name[fr] = bus.dispName; m_age[fr] = 0;
            {m_tag[fr][0], m_val[fr][0]} = resolve(bus.dispTagO, bus.dispValO);
            {m_tag[fr][1], m_val[fr][1]} = resolve(bus.dispTagT, bus.dispValT);
        end
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(m_valid[i]);
        e_full = (cnt >= N - 1);
    endtask

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({bus.ALUworkEn, bus.rsFull, bus.opCode, bus.instAddr, bus.operandO, bus.operandT, bus.wrtTag, bus.wrtName}
                !== {e_work, e_full, e_op, e_addr, e_opo, e_opt, e_wtag, e_name}) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual work=%b full=%b op=%0h addr=%h O=%h T=%h tag=%0h name=%0h required work=%b full=%b op=%0h addr=%h O=%h T=%h tag=%0h name=%0h",
                         $time, bus.ALUworkEn, bus.rsFull, bus.opCode, bus.instAddr, bus.operandO, bus.operandT,
                         bus.wrtTag, bus.wrtName, e_work, e_full, e_op, e_addr, e_opo, e_opt, e_wtag, e_name);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.clear = 0; bus.dispEn = 0; bus.cdbEn = 0; bus.lsbEn = 0;
    endtask

    task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] addr,
                        input logic [31:0] vo, input logic [TAG_W-1:0] to,
                        input logic [31:0] vt, input logic [TAG_W-1:0] tt,
                        input logic [TAG_W-1:0] wt, input logic [NAME_W-1:0] nm);
        bus.dispEn = 1; bus.dispOp = op; bus.dispAddr = addr; bus.dispValO = vo; bus.dispTagO = to;
        bus.dispValT = vt; bus.dispTagT = tt; bus.dispWrtTag = wt; bus.dispName = nm;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [31:0] d);
        bus.cdbEn = 1; bus.cdbTag = t; bus.cdbData = d;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_age[i] = 0; end
        exp_idle(); e_full = 0;
        idle();
        disp(OP_NONE, 0, 0, tagFree, 0, tagFree, 0, 0); bus.dispEn = 0;
        bus.cdbTag = 0; bus.cdbData = 0; bus.lsbTag = 0; bus.lsbData = 0;
        rst = 1;
        tick(); tick();
        cmp_en = 1;
        chk("rst_work", bus.ALUworkEn, 0);
        chk("rst_full", bus.rsFull, 0);
        chk("rst_opO", bus.operandO, dataFree);
        chk("rst_tag", bus.wrtTag, tagFree);
        chk("rst_op", bus.opCode, 0);
        rst = 0;

        // ready ADD issues after the following edge
        disp(OP_ADD, 32'h100, 5, tagFree, 7, tagFree, 3, 1); tick();
        idle(); tick();
        chk("add_work", bus.ALUworkEn, 1);
        chk("add_opO", bus.operandO, 5);
        chk("add_opT", bus.operandT, 7);
        chk("add_tag", bus.wrtTag, 3);
        chk("add_op", bus.opCode, OP_ADD);
        tick();
        chk("add_once", bus.ALUworkEn, 0);

        // wakeup from the ALU bus
        disp(OP_SUB, 32'h104, 0, 2, 11, tagFree, 5, 2); tick();
        idle();
        repeat (3) begin tick(); chk("wait_work", bus.ALUworkEn, 0); end
        cdb(2, 32'h1234); tick();
        idle(); chk("woken_not_yet", bus.ALUworkEn, 0);
        tick();
        chk("wake_work", bus.ALUworkEn, 1);
        chk("wake_opO", bus.operandO, 32'h1234);
        chk("wake_opT", bus.operandT, 11);

        // same-cycle load broadcast bypass at dispatch
        disp(OP_AND, 32'h108, 1, tagFree, 0, 4, 6, 3);
        bus.lsbEn = 1; bus.lsbTag = 4; bus.lsbData = 9; tick();
        idle(); tick();
        chk("byp_work", bus.ALUworkEn, 1);
        chk("byp_opT", bus.operandT, 9);
        tick();

        // fill: entries 0 and 1 wait on tag 0, entry i on tag i
        for (int i = 0; i < 8; i++) begin
            disp(OP_OR, 32'h200 + 32'(i), 32'(i), (i < 2) ? 5'd0 : 5'(i), 1, tagFree, 5'(i), 5'(i)); tick();
            if (i == 5) chk("full_at6", bus.rsFull, 0);
            if (i >= 6) chk("full_at7_8", bus.rsFull, 1);
        end
        idle();
        disp(OP_OR, 32'h2FF, 0, 8, 0, tagFree, 9, 9); tick();
        idle(); chk("full_9th", bus.rsFull, 1);
        cdb(0, 32'hAA); tick();
        idle(); tick();
        chk("drain0_work", bus.ALUworkEn, 1);
        chk("drain0_addr", bus.instAddr, 32'h200);
        chk("drain0_full", bus.rsFull, 1);
        tick();
        chk("drain1_addr", bus.instAddr, 32'h201);
        chk("drain1_full", bus.rsFull, 0);
        for (int t = 2; t < 8; t++) begin cdb(5'(t), 32'(t) * 3); tick(); end
        idle(); tick(); tick();
        cdb(8, 32'h77); tick();
        idle(); tick(); chk("ninth_dropped", bus.ALUworkEn, 0);
        tick(); chk("ninth_dropped2", bus.ALUworkEn, 0);

        // clear with four waiting entries and a same-cycle ready dispatch
        for (int i = 0; i < 4; i++) begin disp(OP_XOR, 32'h300 + 32'(i), 0, 9, 0, tagFree, 1, 1); tick(); end
        disp(OP_XOR, 32'h310, 1, tagFree, 2, tagFree, 1, 1); bus.clear = 1; tick();
        idle();
        chk("clr_work", bus.ALUworkEn, 0);
        chk("clr_full", bus.rsFull, 0);
        tick(); chk("clr_work2", bus.ALUworkEn, 0);
        cdb(9, 32'h55); tick();
        idle(); tick(); chk("clr_nowake", bus.ALUworkEn, 0);
        tick(); chk("clr_nowake2", bus.ALUworkEn, 0);

        // entry 5 older than entry 0, both woken together
        for (int i = 0; i < 5; i++) begin disp(OP_ADD, 32'h400 + 32'(i), 0, 10, 0, tagFree, 2, 2); tick(); end
        disp(OP_ADD, 32'h500, 0, 11, 0, tagFree, 2, 2); tick();
        idle(); cdb(10, 1); tick();
        idle(); repeat (6) tick();
        disp(OP_ADD, 32'h600, 0, 11, 0, tagFree, 2, 2); tick();
        idle(); cdb(11, 2); tick();
        idle(); tick();
`ifdef RS_OLDEST_FIRST_EN
        chk("age_first", bus.instAddr, 32'h500);
        tick(); chk("age_second", bus.instAddr, 32'h600);
`else
        chk("idx_first", bus.instAddr, 32'h600);
        tick(); chk("idx_second", bus.instAddr, 32'h500);
`endif
        tick();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 1) == 1)
                disp(4'($urandom_range(1, 8)), $urandom, $urandom,
                     ($urandom_range(0, 1) == 1) ? tagFree : 5'($urandom_range(0, 7)), $urandom,
                     ($urandom_range(0, 1) == 1) ? tagFree : 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 9) < 4) cdb(5'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 9) < 3) begin
                bus.lsbEn = 1; bus.lsbTag = 5'($urandom_range(0, 7)); bus.lsbData = $urandom;
            end
            bus.clear = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 0; idle();
        tick(); tick();
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
